sr_cmd_driver: RTL and testbench

SR_CMD_DRIVER -- requirements
Module: sr_cmd_driver

---
 rtl/sr_cmd_driver_pkg.sv | 28 ++
 rtl/sr_cmd_driver_if.sv | 29 ++
 rtl/sr_cmd_driver_sync2.sv | 28 ++
 rtl/sr_cmd_driver.sv | 188 ++++++++++++++++++
 tb/tb_sr_cmd_driver.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_cmd_driver_pkg.sv
// -----------------------------------------------------------------------------
// sr_cmd_driver_pkg
// Shared definitions for the SR flip-flop command driver:
//   cmd_t    - two-bit command codes (NOP, SET, RESET, ILLEGAL)
//   state_t  - four-state controller encoding (IDLE, DRIVE, WAIT, RESP)
//   counter widths sized for the legal parameter ranges
//     (pulse 1..15, timeout 1..255)
// -----------------------------------------------------------------------------
package sr_cmd_driver_pkg;

   typedef enum logic [1:0] {
      CMD_NOP     = 2'b00,
      CMD_SET     = 2'b01,
      CMD_RESET   = 2'b10,
      CMD_ILLEGAL = 2'b11
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int PULSE_CNT_W = 4;
   localparam int TO_CNT_W    = 8;

endpackage

// File: rtl/sr_cmd_driver_if.sv
// -----------------------------------------------------------------------------
// sr_cmd_driver_if
// Command / response handshake bundle for sr_cmd_driver.
//   cmd_valid, cmd[1:0], cmd_ready   - command request channel
//   resp_valid, resp_err, resp_ready - completion report channel
// Modports:
//   master - the requester (drives commands, consumes responses)
//   slave  - the driver block itself
// -----------------------------------------------------------------------------
interface sr_cmd_driver_if;

   logic       cmd_valid;
   logic [1:0] cmd;
   logic       cmd_ready;
   logic       resp_valid;
   logic       resp_err;
   logic       resp_ready;

   modport master (
      output cmd_valid, cmd, resp_ready,
      input  cmd_ready, resp_valid, resp_err
   );

   modport slave (
      input  cmd_valid, cmd, resp_ready,
      output cmd_ready, resp_valid, resp_err
   );

endinterface

// File: rtl/sr_cmd_driver_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bit.
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output (two clock cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         q      <= 1'b0;
      end else begin
         r_meta <= d;
         q      <= r_meta;
      end
   end

endmodule

// File: rtl/sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// sr_cmd_driver
// Drives an external SR flip-flop from a command handshake and reports whether
// the flip-flop confirmed the requested state.
// Parameters:
//   PULSE_CYCLES   - cycles S or R is held high per command (1..15)
//   TIMEOUT_CYCLES - WAIT cycles allowed for Q/Q_BAR confirmation (1..255)
// Ports:
//   clk   - single clock
//   rst   - asynchronous active-high reset
//   bus   - command/response handshake (slave side)
//   S, R  - registered set/reset drives to the flip-flop
//   Q, Q_BAR - flip-flop outputs, asynchronous, synchronized internally
// -----------------------------------------------------------------------------
module sr_cmd_driver
   import sr_cmd_driver_pkg::*;
#(
   parameter int PULSE_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic           clk,
   input  logic           rst,
   sr_cmd_driver_if.slave bus,
   output logic           S,
   output logic           R,
   input  logic           Q,
   input  logic           Q_BAR
);

   localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(PULSE_CYCLES - 1);
   localparam logic [TO_CNT_W-1:0]    TO_LAST    = TO_CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                 r_state, w_state_next;
   cmd_t                   r_code, w_code_next;
   logic [PULSE_CNT_W-1:0] r_pulse_cnt, w_pulse_cnt_next;
   logic [TO_CNT_W-1:0]    r_to_cnt, w_to_cnt_next;
   logic                   r_err, w_err_next;
   logic                   r_s, w_s_next;
   logic                   r_r, w_r_next;

   logic [1:0] w_q_async;
   logic [1:0] w_q_sync;
   logic       w_qs;
   logic       w_qbs;
   logic       w_accept;
   logic       w_pulse_done;
   logic       w_timeout;
   logic       w_pair_ok;
   cmd_t       w_cmd_in;

   // ---------------------------------------------------------------- sync
   // bit 0 = Q, bit 1 = Q_BAR
   assign w_q_async = {Q_BAR, Q};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         sync2 u_sync2 (
            .clk (clk),
            .rst (rst),
            .d   (w_q_async[gi]),
            .q   (w_q_sync[gi])
         );
      end
   endgenerate

   assign w_qs  = w_q_sync[0];
   assign w_qbs = w_q_sync[1];

   // ---------------------------------------------------------------- decode
   assign w_cmd_in     = cmd_t'(bus.cmd);
   assign w_accept     = bus.cmd_valid && (r_state == ST_IDLE);
   assign w_pulse_done = (r_pulse_cnt == PULSE_LAST);
   assign w_timeout    = (r_to_cnt == TO_LAST);
   // Only SET and RESET ever reach WAIT, so the code selects the target pair.
   assign w_pair_ok    = (r_code == CMD_SET) ? (w_qs && !w_qbs) : (!w_qs && w_qbs);

   // ---------------------------------------------------------------- state register
   // S/R sit in the same asynchronously reset register bank, so reset drops
   // them immediately and any in-flight command is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_code      <= CMD_NOP;
         r_pulse_cnt <= '0;
         r_to_cnt    <= '0;
         r_err       <= 1'b0;
         r_s         <= 1'b0;
         r_r         <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_code      <= w_code_next;
         r_pulse_cnt <= w_pulse_cnt_next;
         r_to_cnt    <= w_to_cnt_next;
         r_err       <= w_err_next;
         r_s         <= w_s_next;
         r_r         <= w_r_next;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_cmd_in == CMD_SET || w_cmd_in == CMD_RESET) begin
                  w_state_next = ST_DRIVE;
               end else begin
                  w_state_next = ST_RESP;
               end
            end
         end
         ST_DRIVE: begin
            if (w_pulse_done) begin
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_pair_ok || w_timeout) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs / datapath
   // S and R are computed one cycle ahead and registered. Each is qualified
   // by a single latched code, so they can never both be high.
   always_comb begin
      w_code_next      = r_code;
      w_pulse_cnt_next = r_pulse_cnt;
      w_to_cnt_next    = r_to_cnt;
      w_err_next       = r_err;
      w_s_next         = 1'b0;
      w_r_next         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_code_next      = w_cmd_in;
               w_pulse_cnt_next = '0;
               w_err_next       = (w_cmd_in == CMD_ILLEGAL);
               w_s_next         = (w_cmd_in == CMD_SET);
               w_r_next         = (w_cmd_in == CMD_RESET);
            end
         end
         ST_DRIVE: begin
            w_to_cnt_next = '0;
            if (w_pulse_done) begin
               w_pulse_cnt_next = '0;
            end else begin
               w_pulse_cnt_next = r_pulse_cnt + 1'b1;
               w_s_next         = (r_code == CMD_SET);
               w_r_next         = (r_code == CMD_RESET);
            end
         end
         ST_WAIT: begin
            // A match on the final WAIT cycle still counts as success.
            if (w_pair_ok) begin
               w_err_next = 1'b0;
            end else if (w_timeout) begin
               w_err_next = 1'b1;
            end
            if (r_to_cnt != '1) begin
               w_to_cnt_next = r_to_cnt + 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               w_err_next = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready  = (r_state == ST_IDLE);
   assign bus.resp_valid = (r_state == ST_RESP);
   assign bus.resp_err   = r_err;
   assign S              = r_s;
   assign R              = r_r;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_driver
// Self-checking bench for sr_cmd_driver with a behavioural SR flip-flop model
// (optionally stuck at Q=Q_BAR=0) and randomized command traffic.
// -----------------------------------------------------------------------------
module tb_sr_cmd_driver;

   localparam int P = 2;
   localparam int T = 8;

   localparam logic [1:0] C_NOP = 2'b00;
   localparam logic [1:0] C_SET = 2'b01;
   localparam logic [1:0] C_RST = 2'b10;
   localparam logic [1:0] C_ILL = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic S, R, Q, Q_BAR;

   int total = 0;
   int bad   = 0;

   sr_cmd_driver_if bus ();

   sr_cmd_driver #(
      .PULSE_CYCLES   (P),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .S     (S),
      .R     (R),
      .Q     (Q),
      .Q_BAR (Q_BAR)
   );

   always #5 clk = ~clk;

   // Behavioural SR flip-flop: level-sensitive on S/R, optionally stuck low.
   logic ff_state = 1'b0;
   logic stuck    = 1'b0;
   always @(S or R) begin
      if (S)      ff_state = 1'b1;
      else if (R) ff_state = 1'b0;
   end
   assign Q     = stuck ? 1'b0 : ff_state;
   assign Q_BAR = stuck ? 1'b0 : ~ff_state;

   // S and R must never be high together, in any test.
   always @(negedge clk) begin
      total++;
      assert (!(S && R)) else begin
         bad++;
         $display("FAIL s_r_exclusive: S=%b R=%b, required not both high", S, R);
      end
   end

   // Drive one command at the current negedge (DUT idle) and observe until
   // resp_valid appears or a cycle budget runs out (lat stays -1).
   task automatic run_cmd(input logic [1:0] code, input bit noise,
                          output bit acc, output int lat,
                          output int s_cnt, output int r_cnt,
                          output int s_first, output int r_first,
                          output logic err);
      acc = bus.cmd_ready;
      bus.cmd_valid = 1'b1;
      bus.cmd = code;
      lat = -1; s_cnt = 0; r_cnt = 0; s_first = -1; r_first = -1; err = 1'bx;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (noise) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd = 2'($urandom_range(0, 3));
         end else begin
            bus.cmd_valid = 1'b0;
         end
         if (S) begin s_cnt++; if (s_first < 0) s_first = n; end
         if (R) begin r_cnt++; if (r_first < 0) r_first = n; end
         if (bus.resp_valid) begin lat = n; err = bus.resp_err; break; end
      end
   endtask

   // Complete the response handshake; leaves the bench at a negedge in IDLE.
   task automatic finish_resp();
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      bus.cmd_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd = 2'b00; bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (S !== 1'b0 || R !== 1'b0) begin
         bad++; $display("FAIL reset_sr: S=%b R=%b, required 0/0", S, R);
      end
      total++;
      if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
         bad++; $display("FAIL reset_resp: valid=%b err=%b, required 0/0", bus.resp_valid, bus.resp_err);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL reset_ready: cmd_ready=%b, required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_set_reset();
      bit acc; int lat, sc, rc, sf, rf; logic err;
      run_cmd(C_SET, 1'b0, acc, lat, sc, rc, sf, rf, err);
      total++;
      if (acc !== 1'b1 || lat != P + 2 || err !== 1'b0) begin
         bad++; $display("FAIL set_resp: acc=%b lat=%0d err=%b, required 1/%0d/0", acc, lat, err, P + 2);
      end
      total++;
      if (sc != P || sf != 1 || rc != 0) begin
         bad++; $display("FAIL set_pulse: s_cnt=%0d s_first=%0d r_cnt=%0d, required %0d/1/0", sc, sf, rc, P);
      end
      total++;
      if (Q !== 1'b1 || Q_BAR !== 1'b0) begin
         bad++; $display("FAIL set_ff: Q=%b Q_BAR=%b, required 1/0", Q, Q_BAR);
      end
      finish_resp();
      total++;
      if (bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL set_idle: cmd_ready=%b, required 1", bus.cmd_ready);
      end
      run_cmd(C_RST, 1'b0, acc, lat, sc, rc, sf, rf, err);
      total++;
      if (lat != P + 2 || err !== 1'b0) begin
         bad++; $display("FAIL reset_cmd_resp: lat=%0d err=%b, required %0d/0", lat, err, P + 2);
      end
      total++;
      if (rc != P || rf != 1 || sc != 0) begin
         bad++; $display("FAIL reset_cmd_pulse: r_cnt=%0d r_first=%0d s_cnt=%0d, required %0d/1/0", rc, rf, sc, P);
      end
      total++;
      if (Q !== 1'b0 || Q_BAR !== 1'b1) begin
         bad++; $display("FAIL reset_cmd_ff: Q=%b Q_BAR=%b, required 0/1", Q, Q_BAR);
      end
      finish_resp();
   endtask

   task automatic test_stuck();
      bit acc; int lat, sc, rc, sf, rf; logic err;
      stuck = 1'b1;
      @(negedge clk);
      run_cmd(C_SET, 1'b0, acc, lat, sc, rc, sf, rf, err);
      total++;
      if (lat != P + T + 1 || err !== 1'b1) begin
         bad++; $display("FAIL stuck_timeout: lat=%0d err=%b, required %0d/1", lat, err, P + T + 1);
      end
      total++;
      if (sc != P || rc != 0) begin
         bad++; $display("FAIL stuck_pulse: s_cnt=%0d r_cnt=%0d, required %0d/0", sc, rc, P);
      end
      finish_resp();
      stuck = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_illegal_nop();
      bit acc; int lat, sc, rc, sf, rf; logic err;
      run_cmd(C_ILL, 1'b0, acc, lat, sc, rc, sf, rf, err);
      total++;
      if (lat != 1 || err !== 1'b1 || sc != 0 || rc != 0) begin
         bad++; $display("FAIL illegal: lat=%0d err=%b s=%0d r=%0d, required 1/1/0/0", lat, err, sc, rc);
      end
      finish_resp();
      run_cmd(C_NOP, 1'b0, acc, lat, sc, rc, sf, rf, err);
      total++;
      if (lat != 1 || err !== 1'b0 || sc != 0 || rc != 0) begin
         bad++; $display("FAIL nop: lat=%0d err=%b s=%0d r=%0d, required 1/0/0/0", lat, err, sc, rc);
      end
      finish_resp();
   endtask

   task automatic test_backpressure();
      bit acc; int lat, sc, rc, sf, rf; logic err; int got;
      run_cmd(C_SET, 1'b0, acc, lat, sc, rc, sf, rf, err);
      total++;
      if (lat != P + 2 || err !== 1'b0) begin
         bad++; $display("FAIL bp_first: lat=%0d err=%b, required %0d/0", lat, err, P + 2);
      end
      for (int i = 0; i < 5; i++) begin
         bus.cmd_valid = 1'b1; bus.cmd = C_RST;
         @(negedge clk);
         total++;
         if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.cmd_ready !== 1'b0 || R !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: valid=%b err=%b ready=%b R=%b, required 1/0/0/0",
                     i, bus.resp_valid, bus.resp_err, bus.cmd_ready, R);
         end
      end
      // Handshake edge with cmd_valid still high: must not accept here.
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      total++;
      if (bus.cmd_ready !== 1'b1 || R !== 1'b0) begin
         bad++; $display("FAIL bp_no_same_edge: cmd_ready=%b R=%b, required 1/0", bus.cmd_ready, R);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      total++;
      if (R !== 1'b1 || bus.cmd_ready !== 1'b0) begin
         bad++; $display("FAIL bp_accept_after: R=%b cmd_ready=%b, required 1/0", R, bus.cmd_ready);
      end
      got = 0;
      for (int n = 0; n < 50 && !bus.resp_valid; n++) @(negedge clk);
      if (bus.resp_valid) got = 1;
      total++;
      if (got != 1 || bus.resp_err !== 1'b0) begin
         bad++; $display("FAIL bp_second_resp: seen=%0d err=%b, required 1/0", got, bus.resp_err);
      end
      finish_resp();
   endtask

   task automatic test_rst_mid_drive();
      int seen;
      bus.cmd_valid = 1'b1; bus.cmd = C_SET;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      total++;
      if (S !== 1'b1) begin
         bad++; $display("FAIL rst_drive_pre: S=%b, required 1", S);
      end
      rst = 1'b1;
      #1;
      total++;
      if (S !== 1'b0 || R !== 1'b0) begin
         bad++; $display("FAIL rst_async_drop: S=%b R=%b, required 0/0", S, R);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL rst_ready_after: cmd_ready=%b, required 1", bus.cmd_ready);
      end
      seen = 0;
      for (int n = 0; n < 15; n++) begin
         if (bus.resp_valid || S || R) seen++;
         @(negedge clk);
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL rst_discard: activity cycles=%0d, required 0", seen);
      end
   endtask

   task automatic test_random();
      bit acc; int lat, sc, rc, sf, rf; logic err;
      logic [1:0] code; int hold; int exp_lat, exp_s, exp_r; logic exp_err;
      for (int k = 0; k < 40; k++) begin
         code  = 2'($urandom_range(0, 3));
         stuck = ($urandom_range(0, 3) == 0);
         hold  = $urandom_range(0, 3);
         // Reference: timing follows from the command rules directly.
         exp_s = (code == C_SET) ? P : 0;
         exp_r = (code == C_RST) ? P : 0;
         if (code == C_NOP)      begin exp_lat = 1; exp_err = 1'b0; end
         else if (code == C_ILL) begin exp_lat = 1; exp_err = 1'b1; end
         else if (stuck)         begin exp_lat = P + T + 1; exp_err = 1'b1; end
         else                    begin exp_lat = P + 2; exp_err = 1'b0; end
         run_cmd(code, 1'b1, acc, lat, sc, rc, sf, rf, err);
         total++;
         if (acc !== 1'b1 || lat != exp_lat || err !== exp_err || sc != exp_s || rc != exp_r) begin
            bad++;
            $display("FAIL rand%0d cmd=%b stuck=%b: acc=%b lat=%0d err=%b s=%0d r=%0d, required 1/%0d/%b/%0d/%0d",
                     k, code, stuck, acc, lat, err, sc, rc, exp_lat, exp_err, exp_s, exp_r);
         end
         for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd = 2'($urandom_range(0, 3));
            @(negedge clk);
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== exp_err) begin
               bad++;
               $display("FAIL rand%0d_hold%0d: valid=%b err=%b, required 1/%b", k, h, bus.resp_valid, bus.resp_err, exp_err);
            end
         end
         finish_resp();
         total++;
         if (bus.cmd_ready !== 1'b1 || S !== 1'b0 || R !== 1'b0) begin
            bad++;
            $display("FAIL rand%0d_idle: cmd_ready=%b S=%b R=%b, required 1/0/0", k, bus.cmd_ready, S, R);
         end
      end
      stuck = 1'b0;
   endtask

   initial begin
      test_reset();
      test_set_reset();
      test_stuck();
      test_illegal_nop();
      test_backpressure();
      test_rst_mid_drive();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
